// File: rtl/adder_subtractor_binary_serial_if.sv
// Operand/result handshake bundle for the serial adder-subtractor.
// master drives operands and output_ready; slave drives results.
interface adder_subtractor_binary_serial_if #(
  parameter int WORD_WIDTH = 0
);
  logic                  input_valid;
  logic                  input_ready;
  logic [WORD_WIDTH-1:0] A;
  logic [WORD_WIDTH-1:0] B;
  logic                  add_sub;
  logic                  first;
  logic                  last;
  logic                  output_valid;
  logic                  output_ready;
  logic [WORD_WIDTH-1:0] sum;
  logic                  carry_out;
  logic [WORD_WIDTH-1:0] carryin;
  logic                  overflow;
  logic                  result_last;

  modport master (
    output input_valid, A, B, add_sub, first, last, output_ready,
    input  input_ready, output_valid, sum, carry_out, carryin,
    input  overflow, result_last
  );

  modport slave (
    input  input_valid, A, B, add_sub, first, last, output_ready,
    output input_ready, output_valid, sum, carry_out, carryin,
    output overflow, result_last
  );
endinterface

// File: rtl/adder_subtractor_binary_serial.sv
// Word-serial multiword add/subtract, LS word first, one output register.
// Ports: clock, reset_n (async low), bus (slave modport: operand in,
// result out). Macro ADDER_SUBTRACTOR_SERIAL_CARRYIN_EN enables the
// per-bit carryin vector and the overflow flag; otherwise both are 0.
module adder_subtractor_binary_serial #(
  parameter int WORD_WIDTH = 0
) (
  input  logic                             clock,
  input  logic                             reset_n,
  adder_subtractor_binary_serial_if.slave  bus
);

  typedef enum logic {
    IDLE,
    CHAIN
  } state_t;

  state_t                state;
  logic                  carry;
  logic                  mode;
  logic                  out_valid;
  logic [WORD_WIDTH-1:0] sum_q;
  logic                  co_q;
  logic                  rl_q;

  logic                  in_xfer;
  logic                  out_xfer;
  logic                  is_first;
  logic                  mode_n;
  logic                  cin;
  logic [WORD_WIDTH-1:0] b_eff;
  logic [WORD_WIDTH-1:0] sum_n;
  logic                  co_n;

  assign bus.input_ready = !out_valid || bus.output_ready;

  assign in_xfer  = bus.input_valid && bus.input_ready;
  assign out_xfer = out_valid && bus.output_ready;

  // IDLE forces first-word treatment, so a stray first=0 after
  // reset or after a last word still starts a fresh chain.
  assign is_first = bus.first || (state == IDLE);
  assign mode_n   = is_first ? bus.add_sub : mode;
  assign cin      = is_first ? bus.add_sub : carry;
  assign b_eff    = mode_n ? ~bus.B : bus.B;

  assign {co_n, sum_n} = {1'b0, bus.A} + {1'b0, b_eff}
                       + {{WORD_WIDTH{1'b0}}, cin};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      carry     <= 1'b0;
      mode      <= 1'b0;
      out_valid <= 1'b0;
      sum_q     <= '0;
      co_q      <= 1'b0;
      rl_q      <= 1'b0;
    end else if (in_xfer) begin
      state     <= bus.last ? IDLE : CHAIN;
      carry     <= co_n;
      mode      <= mode_n;
      out_valid <= 1'b1;
      sum_q     <= sum_n;
      co_q      <= co_n;
      rl_q      <= bus.last;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.output_valid = out_valid;
  assign bus.sum          = sum_q;
  assign bus.carry_out    = co_q;
  assign bus.result_last  = rl_q;

`ifdef ADDER_SUBTRACTOR_SERIAL_CARRYIN_EN
  logic [WORD_WIDTH-1:0] ci_n;
  logic [WORD_WIDTH-1:0] ci_q;
  logic                  ov_n;
  logic                  ov_q;

  // Sum bit = a ^ b ^ carry-in, so the xor recovers each carry-in.
  assign ci_n = bus.A ^ b_eff ^ sum_n;
  assign ov_n = bus.last && (ci_n[WORD_WIDTH-1] ^ co_n);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ci_q <= '0;
      ov_q <= 1'b0;
    end else if (in_xfer) begin
      ci_q <= ci_n;
      ov_q <= ov_n;
    end
  end

  assign bus.carryin  = ci_q;
  assign bus.overflow = ov_q;
`else
  assign bus.carryin  = '0;
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_adder_subtractor_binary_serial.sv
// Bench: directed vectors plus random multiword traffic against
// an arithmetic reference model and result scoreboard.
module tb_adder_subtractor_binary_serial;
  localparam int W = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  adder_subtractor_binary_serial_if #(.WORD_WIDTH(W)) bus ();

  adder_subtractor_binary_serial #(.WORD_WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic [W-1:0] ci;
    logic         ov;
    logic         rl;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   m_open   = 0;
  bit   m_carry  = 0;
  bit   m_mode   = 0;
  bit   rnd_ready = 0;

  function automatic exp_t lit(logic [W-1:0] s, logic co,
                               logic [W-1:0] ci, logic ov, logic rl);
    exp_t e;
    e.s  = s;
    e.co = co;
    e.ci = ci;
    e.ov = ov;
    e.rl = rl;
`ifndef ADDER_SUBTRACTOR_SERIAL_CARRYIN_EN
    e.ci = '0;
    e.ov = 1'b0;
`endif
    return e;
  endfunction

  // Arithmetic reference: carries from partial sums, overflow from
  // signed range of the top word.
  function automatic exp_t calc(logic [W-1:0] a, logic [W-1:0] b,
                                bit m, bit cin, bit lst);
    int ai, bi, tot, lo, half, sa, sb, st;
    logic [W-1:0] ci;
    ai   = int'(a);
    bi   = int'(b) ^ (m ? (1 << W) - 1 : 0);
    tot  = ai + bi + int'(cin);
    for (int i = 0; i < W; i++) begin
      lo = (1 << i) - 1;
      ci[i] = (((ai & lo) + (bi & lo) + int'(cin)) >> i) != 0;
    end
    half = 1 << (W - 1);
    sa   = ai >= half ? ai - (1 << W) : ai;
    sb   = bi >= half ? bi - (1 << W) : bi;
    st   = sa + sb + int'(cin);
    return lit(tot[W-1:0], tot >= (1 << W), ci,
               lst && (st >= half || st < -half), lst);
  endfunction

  function automatic void model_accept(logic [W-1:0] a, logic [W-1:0] b,
                                       bit as, bit f, bit l);
    bit   isf, m, cin;
    exp_t e;
    isf = f || !m_open;
    m   = isf ? as : m_mode;
    cin = isf ? as : m_carry;
    e   = calc(a, b, m, cin, l);
    q.push_back(e);
    m_open  = !l;
    m_carry = e.co;
    m_mode  = m;
  endfunction

  function automatic exp_t dut_out();
    return {bus.sum, bus.carry_out, bus.carryin,
            bus.overflow, bus.result_last};
  endfunction

  // Compare on the falling edge, then book the transfers that the
  // next rising edge will perform.
  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_open  = 0;
      m_carry = 0;
      m_mode  = 0;
    end else begin
      checks++;
      if (bus.output_valid !== (q.size() != 0)) begin
        failures++;
        $display("FAIL sb_valid got=%b exp=%b",
                 bus.output_valid, q.size() != 0);
      end
      if (bus.output_valid === 1'b1 && q.size() != 0) begin
        checks++;
        if (dut_out() !== q[0]) begin
          failures++;
          $display("FAIL sb_data got=%h exp=%h", dut_out(), q[0]);
        end
      end
      if (bus.output_valid && bus.output_ready && q.size() != 0)
        void'(q.pop_front());
      if (bus.input_valid && bus.input_ready)
        model_accept(bus.A, bus.B, bus.add_sub, bus.first, bus.last);
    end
  end

  task automatic chk(string nm, exp_t got, exp_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_bit(string nm, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  task automatic send(logic [W-1:0] a, logic [W-1:0] b,
                      bit as, bit f, bit l);
    bit acc;
    acc = 0;
    bus.A           = a;
    bus.B           = b;
    bus.add_sub     = as;
    bus.first       = f;
    bus.last        = l;
    bus.input_valid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      if (rnd_ready) bus.output_ready = $urandom_range(0, 3) != 0;
      @(negedge clock);
      acc = bus.input_ready;
      @(posedge clock);
      #1;
    end
    bus.input_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout got=0 exp=1");
    end
  endtask

  task automatic resync();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    bus.output_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.output_ready = 1'b0;
  endtask

  initial begin
    bus.input_valid  = 1'b0;
    bus.A            = '0;
    bus.B            = '0;
    bus.add_sub      = 1'b0;
    bus.first        = 1'b0;
    bus.last         = 1'b0;
    bus.output_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    @(negedge clock);
    chk_bit("reset_valid", bus.output_valid, 1'b0);
    chk("reset_out", dut_out(), exp_t'(0));
    chk("pin_add", calc(8'h7F, 8'h01, 0, 0, 1),
        lit(8'h80, 0, 8'hFE, 1, 1));
    chk("pin_sub", calc(8'h05, 8'h07, 1, 1, 1),
        lit(8'hFE, 0, 8'h03, 0, 1));
    chk("pin_subov", calc(8'h80, 8'h01, 1, 1, 1),
        lit(8'h7F, 1, 8'h01, 1, 1));
    chk("pin_chain", calc(8'h01, 8'h00, 0, 1, 1),
        lit(8'h02, 0, 8'h03, 0, 1));
    resync();

    send(8'h7F, 8'h01, 0, 1, 1);
    @(negedge clock);
    chk("add_single", dut_out(), lit(8'h80, 0, 8'hFE, 1, 1));
    resync();
    drain();

    send(8'hFF, 8'h01, 0, 1, 0);
    @(negedge clock);
    chk("add2_w0", dut_out(), lit(8'h00, 1, 8'hFE, 0, 0));
    resync();
    bus.output_ready = 1'b1;
    send(8'h01, 8'h00, 0, 0, 1);
    bus.output_ready = 1'b0;
    @(negedge clock);
    chk_bit("add2_valid", bus.output_valid, 1'b1);
    chk("add2_w1", dut_out(), lit(8'h02, 0, 8'h03, 0, 1));
    resync();
    drain();

    send(8'h05, 8'h07, 1, 1, 1);
    @(negedge clock);
    chk("sub_neg", dut_out(), lit(8'hFE, 0, 8'h03, 0, 1));
    resync();
    drain();
    send(8'h80, 8'h01, 1, 1, 1);
    @(negedge clock);
    chk("sub_ovf", dut_out(), lit(8'h7F, 1, 8'h01, 1, 1));
    resync();
    drain();

    send(8'h11, 8'h22, 0, 1, 1);
    bus.A           = 8'h33;
    bus.B           = 8'h44;
    bus.add_sub     = 1'b0;
    bus.first       = 1'b1;
    bus.last        = 1'b1;
    bus.input_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk_bit("bp_ready", bus.input_ready, 1'b0);
      chk("bp_hold", dut_out(), lit(8'h33, 0, 8'h00, 0, 1));
      resync();
    end
    bus.output_ready = 1'b1;
    @(negedge clock);
    chk_bit("bp_release", bus.input_ready, 1'b1);
    resync();
    bus.input_valid  = 1'b0;
    bus.output_ready = 1'b0;
    @(negedge clock);
    chk_bit("bp_valid", bus.output_valid, 1'b1);
    chk("bp_new", dut_out(), lit(8'h77, 0, 8'h00, 0, 1));
    resync();
    drain();

    send(8'hFF, 8'h01, 0, 1, 0);
    #1 reset_n = 1'b0;
    #1;
    chk_bit("rst_valid", bus.output_valid, 1'b0);
    chk("rst_out", dut_out(), exp_t'(0));
    #1 reset_n = 1'b1;
    send(8'h01, 8'h00, 0, 0, 1);
    @(negedge clock);
    chk("rst_restart", dut_out(), lit(8'h01, 0, 8'h00, 0, 1));
    resync();
    drain();

    rnd_ready = 1;
    for (int op = 0; op < 300; op++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        bit f;
        f = (w == 0) ? ($urandom_range(0, 3) != 0)
                     : ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0) resync();
        send(W'($urandom), W'($urandom), $urandom_range(0, 1) == 1,
             f, w == nw - 1);
      end
    end
    rnd_ready = 0;
    bus.output_ready = 1'b1;
    repeat (3) resync();
    @(negedge clock);
    chk_bit("final_empty", q.size() == 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_subtractor_binary_serial.md
ADDER_SUBTRACTOR_BINARY_SERIAL -- requirements
Module: adder_subtractor_binary_serial

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 0 (must be set >= 2), meaning bits per word processed per transfer.
REQ-002 SHALL have clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have input_valid  input  1, input_ready  output  1  valid/ready handshake for an operand word.
REQ-005 SHALL have A, B  input  WORD_WIDTH each  operand words, least-significant word first.
REQ-006 SHALL have add_sub  input  1  0 = A+B, 1 = A-B; sampled only on a first word.
REQ-007 SHALL have first, last  input  1 each  mark the first and final word of a multiword operation; both may be 1 together.
REQ-008 SHALL have output_valid  output  1, output_ready  input  1  handshake for a result word.
REQ-009 SHALL have sum  output  WORD_WIDTH, carry_out  output  1, carryin  output  WORD_WIDTH, overflow  output  1, result_last  output  1.

Function
REQ-010 SHALL transfer an input word when input_valid and input_ready are both 1, and an output word when output_valid and output_ready are both 1.
REQ-011 SHALL drive input_ready = (not output_valid) or output_ready, giving full throughput with one output register stage.
REQ-012 SHALL register sum, carry_out, carryin, overflow, result_last on the accepting edge; latency 1 cycle from input transfer to output_valid.
REQ-013 SHALL use two states: IDLE (no operation open) and CHAIN (operation open, carry pending).
REQ-014 SHALL treat an accepted word as first when first=1 or state is IDLE; such a word latches add_sub into the mode register and uses carry-in = mode (0 add, 1 subtract).
REQ-015 SHALL, for a non-first word in CHAIN, use carry-in = carry register from the previous word and the latched mode, ignoring add_sub.
REQ-016 SHALL compute {carry_out, sum} = A + (mode ? ~B : B) + carry-in, full WORD_WIDTH+1-bit result, and store carry_out into the carry register.
REQ-017 SHALL compute carryin = A ^ Beff ^ sum, where Beff is the possibly inverted B, giving the carry into each bit position.
REQ-018 SHALL compute overflow = carryin[WORD_WIDTH-1] ^ carry_out on a last word, and 0 on non-last words.
REQ-019 SHALL copy last to result_last; accepting a last word returns state to IDLE, otherwise state is CHAIN.
REQ-020 SHALL restart the chain when first=1 arrives in CHAIN (abandoned operation's carry discarded).
REQ-021 SHALL hold all outputs stable while output_valid=1 and output_ready=0.
REQ-022 SHALL, on simultaneous output transfer and input transfer, replace the output register with the new result with output_valid staying 1.

Reset
REQ-023 SHALL, on reset_n=0 at any time, immediately force state IDLE, carry and mode registers 0, output_valid 0, and sum, carry_out, carryin, overflow, result_last 0.
REQ-024 SHALL treat the first word accepted after reset as a first word per REQ-014, regardless of its first input.

Configuration
REQ-025 SHALL use macro ADDER_SUBTRACTOR_SERIAL_CARRYIN_EN: when defined, carryin and overflow are computed and registered per REQ-017/018.
REQ-026 SHALL, when ADDER_SUBTRACTOR_SERIAL_CARRYIN_EN is undefined, tie carryin and overflow to constant 0 with no registers for them; all other behaviour unchanged.

Verification (WORD_WIDTH=8, macro defined unless stated)
REQ-027 SHALL test single word A=0x7F B=0x01 add, first=last=1 -> sum 0x80, carry_out 0, carryin 0xFE, overflow 1, result_last 1.
REQ-028 SHALL test two-word add 0x01FF+0x0001: word0 FF+01 -> sum 0x00 carry_out 1 overflow 0; word1 01+00 -> sum 0x02 carry_out 0 overflow 0.
REQ-029 SHALL test single-word subtract A=0x05 B=0x07 -> sum 0xFE, carry_out 0, overflow 0; A=0x80 B=0x01 -> sum 0x7F, carry_out 1, overflow 1.
REQ-030 SHALL test backpressure: output_ready=0 for 5 cycles with input_valid=1 -> input_ready 0, outputs unchanged; then output_ready=1 -> next word accepted same cycle, output_valid stays 1.
REQ-031 SHALL test reset_n pulse after word0 of 0x01FF+0x0001 -> output_valid 0 immediately; next word 01+00 with first=0 -> sum 0x01, carry_out 0.
REQ-032 SHALL test macro undefined: repeat REQ-027 -> sum 0x80, carry_out 0, carryin 0x00, overflow 0.
